// File: rtl/nios_st_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nios_st_pkg
// Purpose : Shared defaults and types for the Avalon-ST packet arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package nios_st_pkg;

   localparam int c_data_w  = 32;
   localparam int c_empty_w = 2;
   localparam int c_err_w   = 1;
   localparam int c_cnt_w   = 16;
   localparam int c_gid_w   = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/nios_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : nios_rr_pick
// Purpose : Rotating priority encoder; first set request at or above ptr.
// Revision: 1.0 - initial release
// ============================================================================
module nios_rr_pick
   import nios_st_pkg::*;
#(
   parameter int NUM_IN = 2
) (
   input  logic [NUM_IN-1:0]  req,
   input  logic [c_gid_w-1:0] ptr,
   output logic [c_gid_w-1:0] idx,
   output logic               any
);

   logic [7:0] w_req_pad;

   function automatic logic [c_gid_w-1:0] wrap_add(input logic [c_gid_w-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_IN) s = s - NUM_IN;
      return c_gid_w'(s);
   endfunction

   always_comb begin
      w_req_pad = '0;
      w_req_pad[NUM_IN-1:0] = req;
   end

   // Walk from the farthest offset back to ptr so the nearest hit wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (w_req_pad[wrap_add(ptr, k)]) begin
            idx = wrap_add(ptr, k);
            any = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/nios_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : nios_st_packet_arbiter
// Purpose : Packet-level round-robin Avalon-ST arbiter with registered output.
// Revision: 1.0 - initial release
// ============================================================================
module nios_st_packet_arbiter
   import nios_st_pkg::*;
#(
   parameter int NUM_IN  = 2,
   parameter int DATA_W  = c_data_w,
   parameter int EMPTY_W = c_empty_w,
   parameter int ERR_W   = c_err_w
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_IN-1:0]           in_valid,
   output logic [NUM_IN-1:0]           in_ready,
   input  logic [NUM_IN*DATA_W-1:0]    in_data,
   input  logic [NUM_IN*ERR_W-1:0]     in_error,
   input  logic [NUM_IN-1:0]           in_startofpacket,
   input  logic [NUM_IN-1:0]           in_endofpacket,
   input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic [ERR_W-1:0]            out_error,
   output logic                        out_startofpacket,
   output logic                        out_endofpacket,
   output logic [EMPTY_W-1:0]          out_empty,
   output logic [c_gid_w-1:0]          grant_id,
   output logic                        busy,
   output logic                        sop_err,
   output logic [NUM_IN*c_cnt_w-1:0]   pkt_done
);

   state_t               r_state;
   logic [c_gid_w-1:0]   r_grant;
   logic [c_gid_w-1:0]   r_rr_ptr;
   logic                 r_first;
   logic                 r_out_valid;
   logic [DATA_W-1:0]    r_out_data;
   logic [ERR_W-1:0]     r_out_error;
   logic                 r_out_sop;
   logic                 r_out_eop;
   logic [EMPTY_W-1:0]   r_out_empty;
   logic                 r_sop_err;
   logic [c_cnt_w-1:0]   r_cnt [NUM_IN];

   logic [c_gid_w-1:0]   w_pick_idx;
   logic                 w_pick_any;
   logic                 w_can_load;
   logic                 w_accept;
   logic                 w_sel_valid;
   logic [DATA_W-1:0]    w_sel_data;
   logic [ERR_W-1:0]     w_sel_error;
   logic                 w_sel_sop;
   logic                 w_sel_eop;
   logic [EMPTY_W-1:0]   w_sel_empty;
   logic [c_gid_w-1:0]   w_next_ptr;

   nios_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
      .req (in_valid),
      .ptr (r_rr_ptr),
      .idx (w_pick_idx),
      .any (w_pick_any)
   );

   assign w_can_load = !r_out_valid || out_ready;
   assign w_accept   = (r_state == BUSY) && w_can_load && w_sel_valid;
   assign w_next_ptr = (r_grant == c_gid_w'(NUM_IN - 1)) ? '0 : r_grant + c_gid_w'(1);

   // Granted-source mux; ready is only ever offered to the granted source.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_data  = '0;
      w_sel_error = '0;
      w_sel_sop   = 1'b0;
      w_sel_eop   = 1'b0;
      w_sel_empty = '0;
      in_ready    = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (r_grant == c_gid_w'(i)) begin
            w_sel_valid = in_valid[i];
            w_sel_data  = in_data[i*DATA_W +: DATA_W];
            w_sel_error = in_error[i*ERR_W +: ERR_W];
            w_sel_sop   = in_startofpacket[i];
            w_sel_eop   = in_endofpacket[i];
            w_sel_empty = in_empty[i*EMPTY_W +: EMPTY_W];
            in_ready[i] = (r_state == BUSY) && w_can_load;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_rr_ptr    <= '0;
         r_first     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_error <= '0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_empty <= '0;
         r_sop_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_grant <= w_pick_idx;
                  r_first <= 1'b1;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (w_accept) begin
                  r_first <= 1'b0;
                  if (r_first ? !w_sel_sop : w_sel_sop) r_sop_err <= 1'b1;
                  if (w_sel_eop) begin
                     r_state  <= IDLE;
                     r_rr_ptr <= w_next_ptr;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase

         // The last beat of a packet may still drain while the FSM arbitrates.
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_error <= w_sel_error;
            r_out_sop   <= w_sel_sop;
            r_out_eop   <= w_sel_eop;
            r_out_empty <= w_sel_empty;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
         if (reset) begin
            r_cnt[gi] <= '0;
         end else if (w_accept && w_sel_eop && (r_grant == c_gid_w'(gi))) begin
            r_cnt[gi] <= r_cnt[gi] + c_cnt_w'(1);
         end
      end
      assign pkt_done[gi*c_cnt_w +: c_cnt_w] = r_cnt[gi];
   end

   assign out_valid         = r_out_valid;
   assign out_data          = r_out_data;
   assign out_error         = r_out_error;
   assign out_startofpacket = r_out_sop;
   assign out_endofpacket   = r_out_eop;
   assign out_empty         = r_out_empty;
   assign grant_id          = r_grant;
   assign busy              = (r_state == BUSY);
   assign sop_err           = r_sop_err;

endmodule
`default_nettype wire

// File: tb/tb_nios_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_nios_st_packet_arbiter
// Purpose : Directed self-checking bench for the packet arbiter (2 sources).
// Revision: 1.0 - initial release
// ============================================================================
module tb_nios_st_packet_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [63:0] in_data;
   logic [1:0]  in_error;
   logic [1:0]  in_sop;
   logic [1:0]  in_eop;
   logic [3:0]  in_empty;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [0:0]  out_error;
   logic        out_sop;
   logic        out_eop;
   logic [1:0]  out_empty;
   logic [2:0]  grant_id;
   logic        busy;
   logic        sop_err;
   logic [31:0] pkt_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nios_st_packet_arbiter dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .in_error          (in_error),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .in_empty          (in_empty),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_error         (out_error),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_empty         (out_empty),
      .grant_id          (grant_id),
      .busy              (busy),
      .sop_err           (sop_err),
      .pkt_done          (pkt_done)
   );

   typedef struct {
      logic [1:0]  v;
      logic [31:0] d;
      logic        sop, eop;
      logic [1:0]  emp;
      logic        err;
      logic        ordy;
      logic [1:0]  x_rdy;
      logic        x_ov, x_busy;
      logic [2:0]  x_gid;
      logic [31:0] x_d;
      logic        x_sop, x_eop;
      logic [1:0]  x_emp;
      logic        x_err;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      in_valid = '0; in_data = '0; in_error = '0;
      in_sop = '0; in_eop = '0; in_empty = '0;
      out_ready = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_ctl", {in_ready, out_valid, busy, grant_id, sop_err}, 64'h0);
      chk("rst_out", {out_data, out_sop, out_eop, out_empty, out_error}, 64'h0);
      chk("rst_cnt", pkt_done, 64'h0);
   endtask

   task automatic drive_beat(input int src, input logic [31:0] d, input logic s, input logic e);
      clear_inputs();
      in_valid[src] = 1'b1;
      in_data[src*32 +: 32] = d;
      in_sop[src] = s;
      in_eop[src] = e;
   endtask

   // Sends one n-beat packet from src with out_ready held high and checks each output beat.
   task automatic send_pkt(input int src, input int n, input logic [31:0] base, input logic [7:0] sop_mask);
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic acc;
      while (got < n && cyc < 30) begin
         if (sent < n) drive_beat(src, base + 32'(sent), sop_mask[sent], sent == n - 1);
         else clear_inputs();
         #1;
         acc = in_valid[src] & in_ready[src];
         @(posedge clk);
         #1;
         cyc++;
         if (acc) sent++;
         if (out_valid) begin
            chk("pkt_beat", {out_data, out_sop}, {base + 32'(got), sop_mask[got]});
            got++;
         end
      end
      chk("pkt_beats_seen", 64'(got), 64'(n));
      clear_inputs();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_q[$];
      int          spkt [2];
      int          sbeat [2];
      int          got;
      int          sent;
      logic [1:0]  acc;

      //            v      d      sop  eop  emp  err ordy x_rdy  ov  bsy gid  x_d     xs   xe   xemp xerr
      tbl[0]  = '{2'b01, 32'h10, 1'b1,1'b0,2'd0,1'b0,1'b1,2'b00,1'b0,1'b1,3'd0,32'h0, 1'b0,1'b0,2'd0,1'b0};
      tbl[1]  = '{2'b01, 32'h10, 1'b1,1'b0,2'd0,1'b0,1'b1,2'b01,1'b1,1'b1,3'd0,32'h10,1'b1,1'b0,2'd0,1'b0};
      tbl[2]  = '{2'b01, 32'h11, 1'b0,1'b0,2'd0,1'b1,1'b1,2'b01,1'b1,1'b1,3'd0,32'h11,1'b0,1'b0,2'd0,1'b1};
      tbl[3]  = '{2'b01, 32'h12, 1'b0,1'b0,2'd0,1'b0,1'b1,2'b01,1'b1,1'b1,3'd0,32'h12,1'b0,1'b0,2'd0,1'b0};
      tbl[4]  = '{2'b01, 32'h13, 1'b0,1'b1,2'd2,1'b0,1'b1,2'b01,1'b1,1'b0,3'd0,32'h13,1'b0,1'b1,2'd2,1'b0};
      tbl[5]  = '{2'b00, 32'h0,  1'b0,1'b0,2'd0,1'b0,1'b1,2'b00,1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,2'd0,1'b0};
      tbl[6]  = '{2'b10, 32'h20, 1'b1,1'b0,2'd0,1'b0,1'b1,2'b00,1'b0,1'b1,3'd1,32'h0, 1'b0,1'b0,2'd0,1'b0};
      tbl[7]  = '{2'b10, 32'h20, 1'b1,1'b0,2'd0,1'b0,1'b1,2'b10,1'b1,1'b1,3'd1,32'h20,1'b1,1'b0,2'd0,1'b0};
      tbl[8]  = '{2'b10, 32'h21, 1'b0,1'b0,2'd0,1'b0,1'b0,2'b00,1'b1,1'b1,3'd1,32'h20,1'b1,1'b0,2'd0,1'b0};
      tbl[9]  = '{2'b10, 32'h21, 1'b0,1'b0,2'd0,1'b0,1'b0,2'b00,1'b1,1'b1,3'd1,32'h20,1'b1,1'b0,2'd0,1'b0};
      tbl[10] = '{2'b10, 32'h21, 1'b0,1'b0,2'd0,1'b0,1'b1,2'b10,1'b1,1'b1,3'd1,32'h21,1'b0,1'b0,2'd0,1'b0};
      tbl[11] = '{2'b10, 32'h22, 1'b0,1'b1,2'd1,1'b1,1'b1,2'b10,1'b1,1'b0,3'd1,32'h22,1'b0,1'b1,2'd1,1'b1};
      tbl[12] = '{2'b00, 32'h0,  1'b0,1'b0,2'd0,1'b0,1'b1,2'b00,1'b0,1'b0,3'd1,32'h0, 1'b0,1'b0,2'd0,1'b0};

      clear_inputs();
      do_reset();

      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("idle", {in_ready, out_valid, busy}, 64'h0);
      end
      chk("idle_cnt", pkt_done, 64'h0);

      // Single packets from table: source 0 four beats, then source 1 under backpressure.
      for (int i = 0; i < 13; i++) begin
         if (i == 6) do_reset();
         in_valid  = tbl[i].v;
         in_data   = {tbl[i].d, tbl[i].d};
         in_sop    = {2{tbl[i].sop}};
         in_eop    = {2{tbl[i].eop}};
         in_empty  = {2{tbl[i].emp}};
         in_error  = {2{tbl[i].err}};
         out_ready = tbl[i].ordy;
         #1;
         chk("tbl_rdy", in_ready, tbl[i].x_rdy);
         @(posedge clk);
         #1;
         chk("tbl_ctl", {out_valid, busy, grant_id}, {tbl[i].x_ov, tbl[i].x_busy, tbl[i].x_gid});
         if (tbl[i].x_ov)
            chk("tbl_beat", {out_data, out_sop, out_eop, out_empty, out_error},
                {tbl[i].x_d, tbl[i].x_sop, tbl[i].x_eop, tbl[i].x_emp, tbl[i].x_err});
         if (i == 5) chk("cnt_src0", pkt_done, 64'h0000_0001);
         if (i == 12) chk("cnt_src1", pkt_done, 64'h0001_0000);
      end

      // Both sources continuously offer 2-beat packets; grants must alternate 0,1,0,1.
      do_reset();
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 2; b++)
            exp_q.push_back(32'((p % 2) << 24 | (p / 2) << 16 | b << 8));
      spkt = '{0, 0};
      sbeat = '{0, 0};
      got = 0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         clear_inputs();
         for (int s = 0; s < 2; s++) begin
            if (spkt[s] < 2) begin
               in_valid[s] = 1'b1;
               in_data[s*32 +: 32] = 32'(s << 24 | spkt[s] << 16 | sbeat[s] << 8);
               in_sop[s] = (sbeat[s] == 0);
               in_eop[s] = (sbeat[s] == 1);
            end
         end
         #1;
         acc = in_valid & in_ready;
         @(posedge clk);
         #1;
         for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
               sbeat[s]++;
               if (sbeat[s] == 2) begin
                  sbeat[s] = 0;
                  spkt[s]++;
               end
            end
         end
         if (out_valid) begin
            if (got < 8) chk("alt_beat", out_data, exp_q[got]);
            got++;
         end
      end
      chk("alt_beats", 64'(got), 64'd8);
      chk("alt_cnt", pkt_done, 64'h0002_0002);
      clear_inputs();

      // Framing: missing sop on first beat, then a good packet, sticky until reset.
      do_reset();
      send_pkt(1, 2, 32'h300, 8'b00);
      chk("sop_err_set", sop_err, 64'h1);
      send_pkt(1, 2, 32'h310, 8'b01);
      chk("sop_err_sticky", sop_err, 64'h1);
      do_reset();
      send_pkt(0, 2, 32'h330, 8'b01);
      chk("sop_err_clean", sop_err, 64'h0);
      send_pkt(0, 3, 32'h320, 8'b011);
      chk("sop_err_mid", sop_err, 64'h1);

      // Reset after beat 2 of a 5-beat packet, then a clean packet from source 1.
      do_reset();
      sent = 0;
      for (int cyc = 0; cyc < 10 && sent < 2; cyc++) begin
         drive_beat(0, 32'h400 + 32'(sent), sent == 0, 1'b0);
         #1;
         acc = in_valid & in_ready;
         @(posedge clk);
         #1;
         if (acc[0]) sent++;
      end
      chk("mid_sent", 64'(sent), 64'd2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_inputs();
      #1;
      chk("mid_rst", {out_valid, busy, in_ready, pkt_done}, 64'h0);
      send_pkt(1, 3, 32'h500, 8'b001);
      chk("mid_gid", grant_id, 64'd1);
      chk("mid_cnt", pkt_done, 64'h0001_0000);
      chk("mid_sop_err", sop_err, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
